llc_req_sequencer: RTL and testbench
====================================

// Module: llc_req_sequencer
// PURPOSE
//  Synthesizable LLC control FSM. Arbitrates processor requests (L1 side) and external snoops into a single
//  tag/MESI/PLRU array port. Sequences hit, fill, victim eviction/writeback, bus ops and L1 messages.
//  Sits between the L1 interface, the LLC tag array and the shared system bus. Keeps read/hit/miss statistics.
// PARAMETERS
//  ADDR_W  32     address width
//  WAYS    16     associativity (WAY_W = $clog2(WAYS))
//  SETS    16384  sets (IDX_W = $clog2(SETS))
//  LINE_B  64     line bytes (OFF_W = $clog2(LINE_B)); TAG_W = ADDR_W-IDX_W-OFF_W
//  CNT_W   32     statistics counter width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous active-high reset
//  pr_valid/pr_ready  in/out 1 processor request handshake; pr_op in 1 (0=READ,1=WRITE); pr_addr in ADDR_W
//  snp_valid/snp_ready in/out 1 snoop handshake; snp_op in bus_op_t; snp_addr in ADDR_W
//  snp_result     out  snoop_result_t  our snoop answer; valid with snp_ready
//  tag_rd_en      out  1       array lookup; tag_idx out IDX_W, tag_tag out TAG_W
//  tag_hit, tag_hit_way, tag_hit_mesi  in 1/WAY_W/mesi_t   same-cycle lookup result
//  tag_full       in   1       no way of set is I; tag_free_way in WAY_W lowest I way
//  vic_way, vic_tag, vic_mesi  in WAY_W/TAG_W/mesi_t   PLRU victim of looked-up set
//  tag_wr_en      out  1       write tag_wr_way/tag_wr_tag/tag_wr_mesi (out WAY_W/TAG_W/mesi_t)
//  plru_upd_en    out  1       touch plru_upd_way (out WAY_W) in tag_idx
//  bus_req/bus_ack  out/in 1   bus handshake; bus_op out bus_op_t; bus_addr out ADDR_W; bus_snp in snoop_result_t (valid with bus_ack)
//  l1_msg_valid   out  1       one-cycle pulse; l1_msg out l1_msg_t; l1_addr out ADDR_W
//  cnt_reads, cnt_writes, cnt_hits, cnt_misses  out CNT_W
// BEHAVIOUR
//  - Reset: FSM=IDLE, all handshake/enable/valid outputs 0, addresses/way/op fields 0, counters 0.
//    rst mid-sequence aborts the operation; the array is not written further.
//  - Arbitration in IDLE: snoop has strict priority over processor (bus snoops cannot be stalled).
//    Accepted request latched; ready is a 1-cycle pulse in IDLE only.
//  - States: IDLE -> LOOKUP -> {HIT_UPD | EVICT | BUS_OP | SNP_UPD} -> ... -> IDLE.
//  - LOOKUP (1 cycle): tag_rd_en=1, array result sampled same cycle.
//  - PR READ hit: HIT_UPD: plru touch, L1 SENDLINE, cnt_hits++. Total 3 cycles accept->IDLE.
//  - PR READ miss: target = tag_free_way if !tag_full else vic_way.
//    When full: EVICT sends L1 EVICTLINE(victim addr). If vic_mesi==M, WRBACK bus WRITE victim addr.
//    BUS_OP: bus READ, hold bus_req/op/addr until bus_ack. FILL: write tag, MESI=E if bus_snp==NOHIT else S;
//    plru touch; SENDLINE. cnt_misses++.
//  - PR WRITE hit M/E: ->M. Hit S: bus INVALIDATE then ->M. Miss: as read miss, but bus RWIM and fill M.
//    All writes: plru touch + SENDLINE.
//  - cnt_reads / cnt_writes increment once at accept; hit/miss once at LOOKUP exit.
//    Counters saturate at all-ones (no wrap).
//  - Snoop (SNP_UPD, answered in 1 cycle after LOOKUP):
//    miss -> NOHIT.
//    READ hit E/S -> HIT, state S. READ hit M -> HITM, state S, then bus WRITE writeback + L1 GETLINE.
//    RWIM/INVALIDATE hit -> NOHIT, state I, L1 INVALIDATELINE; M under RWIM writes back first.
//    Snoops never touch PLRU or counters.
//  - Writeback to a full array while bus_ack is pending: FSM waits indefinitely; no timeout.
//  - Bus cycle: bus_req rises the cycle after state entry, falls the cycle after bus_ack.
//    bus_ack without bus_req is ignored.
// STRUCTURE
//  - mesi_t, bus_op_t (READ,WRITE,INVALIDATE,RWIM), snoop_result_t (NOHIT,HIT,HITM) and
//    l1_msg_t (GETLINE,SENDLINE,INVALIDATELINE,EVICTLINE) come from cache_define.
//    The FSM state enum is local.
//  - Sub-module llc_req_arb: fixed-priority snoop/processor arbiter plus request latch.
//    FSM and counters stay in this module.
// TESTING
//  1 Reset: all outputs 0, pr_ready=snp_ready=0 until a valid arrives.
//  2 PR READ 0x0000_1040, tag_full=0, miss, bus_snp=NOHIT -> bus READ 0x1040; tag_wr way=tag_free_way MESI=E;
//    SENDLINE; cnt_misses=1.
//  3 Repeat READ 0x1040 with hit, MESI=E -> no bus_req, SENDLINE, PLRU touch, cnt_hits=1. Accept->IDLE in 3 cycles.
//  4 PR WRITE to full set, vic_mesi=M, vic_tag=0x5 -> EVICTLINE, bus WRITE victim, bus RWIM, fill MESI=M.
//  5 snp_valid and pr_valid in the same cycle: snoop READ hit M -> snoop served first with HITM, state S,
//    writeback WRITE; processor request served afterwards.
//  6 Counter at 2^CNT_W-1 plus one more hit -> stays saturated.
//    rst asserted during BUS_OP -> bus_req=0 next cycle, no tag write.

Source files
------------

// File: rtl/llc_req_sequencer_pkg.sv
// Shared LLC types: MESI line states, system-bus operations, snoop answers and L1 messages,
// plus the rule for the MESI state a freshly filled line takes.
package cache_define;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    BUS_READ       = 2'd0,
    BUS_WRITE      = 2'd1,
    BUS_INVALIDATE = 2'd2,
    BUS_RWIM       = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    L1_GETLINE        = 2'd0,
    L1_SENDLINE       = 2'd1,
    L1_INVALIDATELINE = 2'd2,
    L1_EVICTLINE      = 2'd3
  } l1_msg_t;

  // Writes always own the line; reads are exclusive only if no other cache answered.
  function automatic mesi_t fill_mesi(input logic is_write, input snoop_result_t snp);
    if (is_write) return MESI_M;
    return (snp == SNP_NOHIT) ? MESI_E : MESI_S;
  endfunction

endpackage

// File: rtl/llc_req_sequencer_arb.sv
// Fixed-priority snoop/processor arbiter with the request latch that feeds the sequencer FSM.
// Bus snoops cannot be stalled, so they always win over a processor request in the same cycle.
module llc_req_arb
  import cache_define::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              pr_valid,
  input  logic              pr_op,
  input  logic [ADDR_W-1:0] pr_addr,
  input  logic              snp_valid,
  input  bus_op_t           snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              pr_grant,
  output logic              snp_grant,
  output logic              req_is_snp,
  output logic              req_write,
  output bus_op_t           req_snp_op,
  output logic [ADDR_W-1:0] req_addr
);

  assign snp_grant = idle && snp_valid;
  assign pr_grant  = idle && pr_valid && !snp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_is_snp <= 1'b0;
      req_write  <= 1'b0;
      req_snp_op <= BUS_READ;
      req_addr   <= '0;
    end else if (snp_grant) begin
      req_is_snp <= 1'b1;
      req_write  <= 1'b0;
      req_snp_op <= snp_op;
      req_addr   <= snp_addr;
    end else if (pr_grant) begin
      req_is_snp <= 1'b0;
      req_write  <= pr_op;
      req_snp_op <= BUS_READ;
      req_addr   <= pr_addr;
    end
  end

endmodule

// File: rtl/llc_req_sequencer.sv
// LLC control FSM: serialises snoops and processor requests onto one tag/MESI/PLRU array port and
// sequences hits, fills, victim eviction/writeback, bus operations, L1 messages and statistics.
//
//   state   | meaning
//   IDLE    | waiting for a snoop or processor request
//   LOOKUP  | array read, result sampled this cycle
//   HIT_UPD | processor hit: PLRU touch, SENDLINE, optional ->M write
//   EVICT   | full set: EVICTLINE to L1 for the PLRU victim
//   WRBACK  | bus WRITE of a dirty victim
//   BUS_OP  | bus READ / RWIM / INVALIDATE for the request line
//   FILL    | tag/MESI write, PLRU touch, SENDLINE
//   SNP_UPD | snoop answered, MESI downgraded / invalidated
//   SNP_WB  | bus WRITE of a line a snoop found modified
//   SNP_INV | INVALIDATELINE to L1 after an RWIM writeback
module llc_req_sequencer
  import cache_define::*;
#(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 16,
  parameter int SETS   = 16384,
  parameter int LINE_B = 64,
  parameter int CNT_W  = 32,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS),
  localparam int OFF_W = $clog2(LINE_B),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pr_valid,
  output logic              pr_ready,
  input  logic              pr_op,
  input  logic [ADDR_W-1:0] pr_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  bus_op_t           snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output snoop_result_t     snp_result,
  output logic              tag_rd_en,
  output logic [IDX_W-1:0]  tag_idx,
  output logic [TAG_W-1:0]  tag_tag,
  input  logic              tag_hit,
  input  logic [WAY_W-1:0]  tag_hit_way,
  input  mesi_t             tag_hit_mesi,
  input  logic              tag_full,
  input  logic [WAY_W-1:0]  tag_free_way,
  input  logic [WAY_W-1:0]  vic_way,
  input  logic [TAG_W-1:0]  vic_tag,
  input  mesi_t             vic_mesi,
  output logic              tag_wr_en,
  output logic [WAY_W-1:0]  tag_wr_way,
  output logic [TAG_W-1:0]  tag_wr_tag,
  output mesi_t             tag_wr_mesi,
  output logic              plru_upd_en,
  output logic [WAY_W-1:0]  plru_upd_way,
  output logic              bus_req,
  input  logic              bus_ack,
  output bus_op_t           bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  snoop_result_t     bus_snp,
  output logic              l1_msg_valid,
  output l1_msg_t           l1_msg,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [CNT_W-1:0]  cnt_reads,
  output logic [CNT_W-1:0]  cnt_writes,
  output logic [CNT_W-1:0]  cnt_hits,
  output logic [CNT_W-1:0]  cnt_misses
);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, HIT_UPD, EVICT, WRBACK, BUS_OP, FILL, SNP_UPD, SNP_WB, SNP_INV
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state;
  logic              pr_grant, snp_grant;
  logic              req_is_snp, req_write;
  bus_op_t           req_snp_op;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WAY_W-1:0]  tgt_way;
  logic [TAG_W-1:0]  vic_tag_q;
  mesi_t             vic_mesi_q;
  logic              snp_wb_q, snp_inv_q;
  logic              bus_done;

  llc_req_arb #(.ADDR_W(ADDR_W)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .idle       (state == IDLE),
    .pr_valid   (pr_valid),
    .pr_op      (pr_op),
    .pr_addr    (pr_addr),
    .snp_valid  (snp_valid),
    .snp_op     (snp_op),
    .snp_addr   (snp_addr),
    .pr_grant   (pr_grant),
    .snp_grant  (snp_grant),
    .req_is_snp (req_is_snp),
    .req_write  (req_write),
    .req_snp_op (req_snp_op),
    .req_addr   (req_addr)
  );

  assign pr_ready = pr_grant;
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign tag_idx  = req_idx;
  assign tag_tag  = req_tag;
  // An ack only completes a bus cycle we are actually requesting.
  assign bus_done = bus_req && bus_ack;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      snp_ready    <= 1'b0;
      snp_result   <= SNP_NOHIT;
      tag_rd_en    <= 1'b0;
      tag_wr_en    <= 1'b0;
      tag_wr_way   <= '0;
      tag_wr_tag   <= '0;
      tag_wr_mesi  <= MESI_I;
      plru_upd_en  <= 1'b0;
      plru_upd_way <= '0;
      bus_req      <= 1'b0;
      bus_op       <= BUS_READ;
      bus_addr     <= '0;
      l1_msg_valid <= 1'b0;
      l1_msg       <= L1_GETLINE;
      l1_addr      <= '0;
      cnt_reads    <= '0;
      cnt_writes   <= '0;
      cnt_hits     <= '0;
      cnt_misses   <= '0;
      tgt_way      <= '0;
      vic_tag_q    <= '0;
      vic_mesi_q   <= MESI_I;
      snp_wb_q     <= 1'b0;
      snp_inv_q    <= 1'b0;
    end else begin
      tag_rd_en    <= 1'b0;
      tag_wr_en    <= 1'b0;
      plru_upd_en  <= 1'b0;
      l1_msg_valid <= 1'b0;
      snp_ready    <= 1'b0;

      if (pr_grant && !pr_op && !(&cnt_reads))  cnt_reads  <= cnt_reads + CNT_ONE;
      if (pr_grant && pr_op && !(&cnt_writes))  cnt_writes <= cnt_writes + CNT_ONE;

      case (state)
        IDLE: begin
          if (pr_grant || snp_grant) begin
            state     <= LOOKUP;
            tag_rd_en <= 1'b1;
          end
        end

        LOOKUP: begin
          if (req_is_snp) begin
            state      <= SNP_UPD;
            snp_ready  <= 1'b1;
            snp_result <= SNP_NOHIT;
            snp_wb_q   <= 1'b0;
            snp_inv_q  <= 1'b0;
            if (tag_hit) begin
              tag_wr_way <= tag_hit_way;
              tag_wr_tag <= req_tag;
              l1_addr    <= line_addr(req_tag, req_idx);
              case (req_snp_op)
                BUS_READ: begin
                  tag_wr_en   <= 1'b1;
                  tag_wr_mesi <= MESI_S;
                  if (tag_hit_mesi == MESI_M) begin
                    snp_result   <= SNP_HITM;
                    snp_wb_q     <= 1'b1;
                    l1_msg_valid <= 1'b1;
                    l1_msg       <= L1_GETLINE;
                  end else begin
                    snp_result <= SNP_HIT;
                  end
                end
                BUS_RWIM, BUS_INVALIDATE: begin
                  tag_wr_en    <= 1'b1;
                  tag_wr_mesi  <= MESI_I;
                  l1_msg_valid <= 1'b1;
                  // Dirty data is pulled from L1 and written back before L1 drops the line.
                  if (req_snp_op == BUS_RWIM && tag_hit_mesi == MESI_M) begin
                    l1_msg    <= L1_GETLINE;
                    snp_wb_q  <= 1'b1;
                    snp_inv_q <= 1'b1;
                  end else begin
                    l1_msg <= L1_INVALIDATELINE;
                  end
                end
                default: ;
              endcase
            end
          end else if (tag_hit) begin
            if (!(&cnt_hits)) cnt_hits <= cnt_hits + CNT_ONE;
            tgt_way <= tag_hit_way;
            if (req_write && tag_hit_mesi == MESI_S) begin
              state    <= BUS_OP;
              bus_op   <= BUS_INVALIDATE;
              bus_addr <= line_addr(req_tag, req_idx);
            end else begin
              state        <= HIT_UPD;
              plru_upd_en  <= 1'b1;
              plru_upd_way <= tag_hit_way;
              l1_msg_valid <= 1'b1;
              l1_msg       <= L1_SENDLINE;
              l1_addr      <= req_addr;
              if (req_write) begin
                tag_wr_en   <= 1'b1;
                tag_wr_way  <= tag_hit_way;
                tag_wr_tag  <= req_tag;
                tag_wr_mesi <= MESI_M;
              end
            end
          end else begin
            if (!(&cnt_misses)) cnt_misses <= cnt_misses + CNT_ONE;
            if (tag_full) begin
              state        <= EVICT;
              tgt_way      <= vic_way;
              vic_tag_q    <= vic_tag;
              vic_mesi_q   <= vic_mesi;
              l1_msg_valid <= 1'b1;
              l1_msg       <= L1_EVICTLINE;
              l1_addr      <= line_addr(vic_tag, req_idx);
            end else begin
              state    <= BUS_OP;
              tgt_way  <= tag_free_way;
              bus_op   <= req_write ? BUS_RWIM : BUS_READ;
              bus_addr <= line_addr(req_tag, req_idx);
            end
          end
        end

        EVICT: begin
          if (vic_mesi_q == MESI_M) begin
            state    <= WRBACK;
            bus_op   <= BUS_WRITE;
            bus_addr <= line_addr(vic_tag_q, req_idx);
          end else begin
            state    <= BUS_OP;
            bus_op   <= req_write ? BUS_RWIM : BUS_READ;
            bus_addr <= line_addr(req_tag, req_idx);
          end
        end

        WRBACK: begin
          if (!bus_req) bus_req <= 1'b1;
          if (bus_done) begin
            bus_req  <= 1'b0;
            state    <= BUS_OP;
            bus_op   <= req_write ? BUS_RWIM : BUS_READ;
            bus_addr <= line_addr(req_tag, req_idx);
          end
        end

        BUS_OP: begin
          if (!bus_req) bus_req <= 1'b1;
          if (bus_done) begin
            bus_req      <= 1'b0;
            state        <= FILL;
            tag_wr_en    <= 1'b1;
            tag_wr_way   <= tgt_way;
            tag_wr_tag   <= req_tag;
            tag_wr_mesi  <= fill_mesi(req_write, bus_snp);
            plru_upd_en  <= 1'b1;
            plru_upd_way <= tgt_way;
            l1_msg_valid <= 1'b1;
            l1_msg       <= L1_SENDLINE;
            l1_addr      <= req_addr;
          end
        end

        HIT_UPD, FILL, SNP_INV: state <= IDLE;

        SNP_UPD: begin
          if (snp_wb_q) begin
            state    <= SNP_WB;
            bus_op   <= BUS_WRITE;
            bus_addr <= line_addr(req_tag, req_idx);
          end else begin
            state <= IDLE;
          end
        end

        SNP_WB: begin
          if (!bus_req) bus_req <= 1'b1;
          if (bus_done) begin
            bus_req <= 1'b0;
            if (snp_inv_q) begin
              state        <= SNP_INV;
              l1_msg_valid <= 1'b1;
              l1_msg       <= L1_INVALIDATELINE;
              l1_addr      <= line_addr(req_tag, req_idx);
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_req_sequencer.sv
// Directed bench for llc_req_sequencer: the bench plays the tag array and the system bus and
// checks each step against hand-computed values.
module tb_llc_req_sequencer;
  import cache_define::*;

  localparam int ADDR_W = 32;
  localparam int WAY_W  = 4;
  localparam int IDX_W  = 14;
  localparam int TAG_W  = 12;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pr_valid = 1'b0, pr_ready, pr_op = 1'b0;
  logic [ADDR_W-1:0] pr_addr = '0;
  logic              snp_valid = 1'b0, snp_ready;
  bus_op_t           snp_op = BUS_READ;
  logic [ADDR_W-1:0] snp_addr = '0;
  snoop_result_t     snp_result;
  logic              tag_rd_en;
  logic [IDX_W-1:0]  tag_idx;
  logic [TAG_W-1:0]  tag_tag;
  logic              tag_hit = 1'b0;
  logic [WAY_W-1:0]  tag_hit_way = '0;
  mesi_t             tag_hit_mesi = MESI_I;
  logic              tag_full = 1'b0;
  logic [WAY_W-1:0]  tag_free_way = '0;
  logic [WAY_W-1:0]  vic_way = '0;
  logic [TAG_W-1:0]  vic_tag = '0;
  mesi_t             vic_mesi = MESI_I;
  logic              tag_wr_en;
  logic [WAY_W-1:0]  tag_wr_way;
  logic [TAG_W-1:0]  tag_wr_tag;
  mesi_t             tag_wr_mesi;
  logic              plru_upd_en;
  logic [WAY_W-1:0]  plru_upd_way;
  logic              bus_req, bus_ack = 1'b0;
  bus_op_t           bus_op;
  logic [ADDR_W-1:0] bus_addr;
  snoop_result_t     bus_snp = SNP_NOHIT;
  logic              l1_msg_valid;
  l1_msg_t           l1_msg;
  logic [ADDR_W-1:0] l1_addr;
  logic [CNT_W-1:0]  cnt_reads, cnt_writes, cnt_hits, cnt_misses;

  int n_assert = 0;
  int n_fail   = 0;

  llc_req_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_op(pr_op), .pr_addr(pr_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .snp_result(snp_result),
    .tag_rd_en(tag_rd_en), .tag_idx(tag_idx), .tag_tag(tag_tag),
    .tag_hit(tag_hit), .tag_hit_way(tag_hit_way), .tag_hit_mesi(tag_hit_mesi),
    .tag_full(tag_full), .tag_free_way(tag_free_way),
    .vic_way(vic_way), .vic_tag(vic_tag), .vic_mesi(vic_mesi),
    .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag),
    .tag_wr_mesi(tag_wr_mesi),
    .plru_upd_en(plru_upd_en), .plru_upd_way(plru_upd_way),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_snp(bus_snp),
    .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_addr(l1_addr),
    .cnt_reads(cnt_reads), .cnt_writes(cnt_writes), .cnt_hits(cnt_hits),
    .cnt_misses(cnt_misses)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_req(input string tag);
    int n = 0;
    while (!bus_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, bus_req, 1'b1);
  endtask

  task automatic ack_bus();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
  endtask

  task automatic read_hit(input logic [ADDR_W-1:0] a, input logic [WAY_W-1:0] way);
    tag_hit = 1'b1; tag_hit_way = way; tag_hit_mesi = MESI_E;
    pr_valid = 1'b1; pr_op = 1'b0; pr_addr = a;
    tick();
    pr_valid = 1'b0;
    tick();
    tick();
  endtask

  // Leaves the FSM in SNP_UPD with the answer visible; caller checks then releases.
  task automatic do_snoop(input bus_op_t op, input logic [ADDR_W-1:0] a);
    snp_valid = 1'b1; snp_op = op; snp_addr = a;
    tick();
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_bus_req", bus_req, 0);
    check("rst_enables", {tag_rd_en, tag_wr_en, plru_upd_en, l1_msg_valid, snp_ready}, 0);
    check("rst_addrs", {bus_addr, l1_addr}, 0);
    check("rst_counters", {cnt_reads, cnt_writes, cnt_hits, cnt_misses}, 0);
    rst = 1'b0;
    tick();
    check("idle_readies", {pr_ready, snp_ready}, 0);
    check("idle_result", snp_result, SNP_NOHIT);

    // READ miss with free way, no sharers -> fill E
    tag_hit = 1'b0; tag_full = 1'b0; tag_free_way = 4'd3; bus_snp = SNP_NOHIT;
    pr_valid = 1'b1; pr_op = 1'b0; pr_addr = 32'h0000_1040;
    #1;
    check("rd_miss_ready", pr_ready, 1);
    tick();
    pr_valid = 1'b0;
    check("rd_miss_lookup", {tag_rd_en, tag_idx, tag_tag}, {1'b1, 14'h41, 12'h0});
    check("rd_cnt_reads", cnt_reads, 1);
    tick();
    check("rd_miss_no_early_req", {tag_rd_en, bus_req}, 0);
    check("rd_cnt_misses", cnt_misses, 1);
    wait_bus_req("rd_miss");
    check("rd_miss_bus", {bus_op, bus_addr}, {BUS_READ, 32'h0000_1040});
    ack_bus();
    check("rd_fill_tag", {bus_req, tag_wr_en, tag_wr_way, tag_wr_tag, tag_wr_mesi},
          {1'b0, 1'b1, 4'd3, 12'h0, MESI_E});
    check("rd_fill_plru", {plru_upd_en, plru_upd_way}, {1'b1, 4'd3});
    check("rd_fill_l1", {l1_msg_valid, l1_msg, l1_addr}, {1'b1, L1_SENDLINE, 32'h0000_1040});
    tick();
    check("rd_fill_pulse_end", {l1_msg_valid, tag_wr_en, plru_upd_en}, 0);

    // READ hit E -> no bus, PLRU touch, SENDLINE, back in IDLE after 3 cycles
    tag_hit = 1'b1; tag_hit_way = 4'd3; tag_hit_mesi = MESI_E;
    pr_valid = 1'b1; pr_op = 1'b0; pr_addr = 32'h0000_1040;
    tick();
    pr_valid = 1'b0;
    tick();
    check("rd_hit_outputs", {bus_req, tag_wr_en, plru_upd_en, plru_upd_way, l1_msg_valid, l1_msg},
          {1'b0, 1'b0, 1'b1, 4'd3, 1'b1, L1_SENDLINE});
    check("rd_hit_cnt", cnt_hits, 1);
    // Next request: WRITE to a full set with a dirty victim
    tag_hit = 1'b0; tag_full = 1'b1; vic_way = 4'd7; vic_tag = 12'h5; vic_mesi = MESI_M;
    pr_valid = 1'b1; pr_op = 1'b1; pr_addr = 32'h0000_2080;
    #1;
    check("rd_hit_busy", pr_ready, 0);
    tick();
    check("rd_hit_3cyc_idle", pr_ready, 1);

    tick();
    pr_valid = 1'b0;
    check("wr_cnt_writes", cnt_writes, 1);
    tick();
    check("wr_evict_l1", {l1_msg_valid, l1_msg, l1_addr}, {1'b1, L1_EVICTLINE, 32'h0050_2080});
    check("wr_cnt_misses", cnt_misses, 2);
    wait_bus_req("wr_wb");
    check("wr_wb_bus", {bus_op, bus_addr}, {BUS_WRITE, 32'h0050_2080});
    ack_bus();
    check("wr_wb_req_fall", bus_req, 0);
    bus_snp = SNP_HIT;
    wait_bus_req("wr_rwim");
    check("wr_rwim_bus", {bus_op, bus_addr}, {BUS_RWIM, 32'h0000_2080});
    ack_bus();
    check("wr_fill_tag", {tag_wr_en, tag_wr_way, tag_wr_tag, tag_wr_mesi},
          {1'b1, 4'd7, 12'h0, MESI_M});
    check("wr_fill_l1", {plru_upd_en, plru_upd_way, l1_msg_valid, l1_msg},
          {1'b1, 4'd7, 1'b1, L1_SENDLINE});
    tick();

    // Snoop READ hit M and processor READ arrive together: snoop first
    tag_hit = 1'b1; tag_hit_way = 4'd2; tag_hit_mesi = MESI_M; tag_full = 1'b0;
    snp_valid = 1'b1; snp_op = BUS_READ; snp_addr = 32'h0000_3000;
    pr_valid = 1'b1; pr_op = 1'b0; pr_addr = 32'h0000_1040;
    #1;
    check("arb_pr_blocked", pr_ready, 0);
    tick();
    check("arb_snoop_idx", tag_idx, 14'hC0);
    tick();
    check("snp_hitm", {snp_ready, snp_result}, {1'b1, SNP_HITM});
    check("snp_hitm_tag", {tag_wr_en, tag_wr_way, tag_wr_mesi, plru_upd_en},
          {1'b1, 4'd2, MESI_S, 1'b0});
    check("snp_hitm_l1", {l1_msg_valid, l1_msg, l1_addr}, {1'b1, L1_GETLINE, 32'h0000_3000});
    snp_valid = 1'b0;
    tick();
    check("snp_ready_pulse", {snp_ready, pr_ready}, 0);
    tag_hit_way = 4'd3; tag_hit_mesi = MESI_E;
    wait_bus_req("snp_wb");
    check("snp_wb_bus", {bus_op, bus_addr}, {BUS_WRITE, 32'h0000_3000});
    ack_bus();
    check("pr_after_snoop_ready", {bus_req, pr_ready}, {1'b0, 1'b1});
    tick();
    pr_valid = 1'b0;
    check("pr_after_snoop_idx", tag_idx, 14'h41);
    tick();
    check("pr_after_snoop_hit", {l1_msg_valid, l1_msg, cnt_hits}, {1'b1, L1_SENDLINE, 4'd2});
    check("snoop_not_counted", cnt_reads, 3);
    tick();

    // Snoop READ hit E -> HIT, line shared, nothing to L1
    tag_hit = 1'b1; tag_hit_way = 4'd5; tag_hit_mesi = MESI_E;
    do_snoop(BUS_READ, 32'h0000_4000);
    check("snp_hit_e", {snp_ready, snp_result, tag_wr_en, tag_wr_way, tag_wr_mesi, l1_msg_valid},
          {1'b1, SNP_HIT, 1'b1, 4'd5, MESI_S, 1'b0});
    snp_valid = 1'b0;
    tick();
    // Snoop miss -> NOHIT, no array write
    tag_hit = 1'b0;
    do_snoop(BUS_READ, 32'h0000_4040);
    check("snp_miss", {snp_ready, snp_result, tag_wr_en}, {1'b1, SNP_NOHIT, 1'b0});
    snp_valid = 1'b0;
    tick();
    // Snoop RWIM hit E -> NOHIT, invalidate in array and L1
    tag_hit = 1'b1; tag_hit_way = 4'd4; tag_hit_mesi = MESI_E;
    do_snoop(BUS_RWIM, 32'h0000_4000);
    check("snp_rwim", {snp_result, tag_wr_en, tag_wr_way, tag_wr_mesi, l1_msg_valid, l1_msg},
          {SNP_NOHIT, 1'b1, 4'd4, MESI_I, 1'b1, L1_INVALIDATELINE});
    snp_valid = 1'b0;
    tick();
    check("snp_rwim_no_bus", bus_req, 0);

    // Counter saturation: hits 2 -> 15 after 13 more, then stays
    for (int i = 0; i < 13; i++) read_hit(32'h0000_1040, 4'd3);
    check("hit_reach_max", cnt_hits, 4'hF);
    read_hit(32'h0000_1040, 4'd3);
    check("hit_saturated", cnt_hits, 4'hF);
    check("reads_saturated", cnt_reads, 4'hF);

    // Reset during BUS_OP aborts the fill
    tag_hit = 1'b0; tag_full = 1'b0; tag_free_way = 4'd1;
    pr_valid = 1'b1; pr_op = 1'b0; pr_addr = 32'h0000_5040;
    tick();
    pr_valid = 1'b0;
    tick();
    wait_bus_req("rst_mid");
    rst = 1'b1; bus_ack = 1'b1;
    tick();
    check("rst_mid_req_drop", {bus_req, tag_wr_en}, 0);
    rst = 1'b0;
    tick();
    check("rst_mid_no_fill", {bus_req, tag_wr_en, l1_msg_valid, plru_upd_en}, 0);
    check("rst_mid_counters", {cnt_reads, cnt_hits}, 0);
    bus_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
